// File: rtl/hex_keypad_scanner_pkg.sv
// Shared encodings for the hex keypad scanner: debounce FSM states,
// scan classification and the row/column keymap.
package hex_keypad_scanner_pkg;

    // Debounce FSM states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_ACCEPT   = 2'd2;
    localparam logic [1:0] ST_HELD     = 2'd3;

    // Outcome of one full four-column scan
    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_class_t;

    // Keymap lookup; idx = row*4 + col
    function automatic logic [3:0] key_decode(input logic [3:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd0:    nib = 4'h1;
            4'd1:    nib = 4'h2;
            4'd2:    nib = 4'h3;
            4'd3:    nib = 4'hA;
            4'd4:    nib = 4'h4;
            4'd5:    nib = 4'h5;
            4'd6:    nib = 4'h6;
            4'd7:    nib = 4'hB;
            4'd8:    nib = 4'h7;
            4'd9:    nib = 4'h8;
            4'd10:   nib = 4'h9;
            4'd11:   nib = 4'hC;
            4'd12:   nib = 4'hE;
            4'd13:   nib = 4'h0;
            4'd14:   nib = 4'hF;
            default: nib = 4'hD;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_debounce.sv
// Press/release debouncer for the keypad scanner. Consumes one classified
// scan result per full scan and emits a single accept pulse per press.
module keypad_debounce
    import hex_keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_done,
    input  scan_class_t scan_class,
    input  logic [3:0]  scan_code,
    output logic        accept,
    output logic [3:0]  code
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] rel_cnt_reg, rel_cnt_next;
    logic [3:0]       cand_reg, cand_next;

    // Next-state logic; only the ACCEPT state advances without a scan result
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rel_cnt_next = rel_cnt_reg;
        cand_next    = cand_reg;
        case (state_reg)
            ST_IDLE: begin
                if (scan_done && scan_class == SCAN_SINGLE) begin
                    cand_next = scan_code;
                    cnt_next  = CNT_ONE;
                    if (DEBOUNCE_SCANS == 1) state_next = ST_ACCEPT;
                    else                     state_next = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (scan_done) begin
                    if (scan_class == SCAN_SINGLE && scan_code == cand_reg) begin
                        cnt_next = cnt_reg + CNT_ONE;
                        if (cnt_reg + CNT_ONE == CNT_TARGET) state_next = ST_ACCEPT;
                    end else if (scan_class == SCAN_SINGLE) begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_ACCEPT: begin
                rel_cnt_next = '0;
                state_next   = ST_HELD;
            end
            default: begin
                // HELD: wait for enough consecutive empty scans; any key activity restarts the count
                if (scan_done) begin
                    if (scan_class == SCAN_NONE) begin
                        rel_cnt_next = rel_cnt_reg + CNT_ONE;
                        if (rel_cnt_reg + CNT_ONE == CNT_TARGET) begin
                            rel_cnt_next = '0;
                            state_next   = ST_IDLE;
                        end
                    end else begin
                        rel_cnt_next = '0;
                    end
                end
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            rel_cnt_reg <= '0;
            cand_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rel_cnt_reg <= rel_cnt_next;
            cand_reg    <= cand_next;
        end
    end

    assign accept = (state_reg == ST_ACCEPT);
    assign code   = cand_reg;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column per slot, samples
// the synchronised rows, classifies each full scan and shifts debounced key
// nibbles into a 16-bit entry register.
module hex_keypad_scanner
    import hex_keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] data
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_DIV - 1);

    logic [3:0]        row_meta_reg, row_sync_reg;
    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [1:0]        col_idx_reg;
    logic [15:0]       hit_map_reg, hit_map_next;
    logic              slot_last, scan_end;
    logic [4:0]        hit_count;
    logic [3:0]        hit_idx;
    scan_class_t       scan_class_next, scan_class_reg;
    logic              scan_done_reg;
    logic [3:0]        scan_code_reg;
    logic              accept;
    logic [3:0]        accept_code;
    logic [3:0]        key_code_reg;
    logic [15:0]       data_reg;

    // Two-flop synchroniser; resets to the idle (all released) row level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign slot_last = (slot_cnt_reg == SLOT_MAX);
    assign scan_end  = slot_last && (col_idx_reg == 2'd3);

    // Slot enable counter and column rotation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_reg <= '0;
            col_idx_reg  <= 2'd0;
        end else if (slot_last) begin
            slot_cnt_reg <= '0;
            col_idx_reg  <= col_idx_reg + 2'd1;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col[gi] = (col_idx_reg != 2'(gi));
        end
        // Hit map bit row*4+col; the active column is refreshed on its slot's last cycle
        for (gi = 0; gi < 16; gi++) begin : g_map
            assign hit_map_next[gi] = (slot_last && col_idx_reg == 2'(gi % 4))
                                    ? ~row_sync_reg[gi / 4] : hit_map_reg[gi];
        end
    endgenerate

    // Count intersections in the (about to complete) scan and locate a lone hit
    always_comb begin
        hit_count = 5'd0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit_map_next[i]) begin
                hit_count = hit_count + 5'd1;
                hit_idx   = 4'(i);
            end
        end
        if (hit_count == 5'd0)      scan_class_next = SCAN_NONE;
        else if (hit_count == 5'd1) scan_class_next = SCAN_SINGLE;
        else                        scan_class_next = SCAN_MULTI;
    end

    // Hit map storage and registered scan result handed to the debouncer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_map_reg    <= '0;
            scan_done_reg  <= 1'b0;
            scan_class_reg <= SCAN_NONE;
            scan_code_reg  <= '0;
        end else begin
            hit_map_reg   <= hit_map_next;
            scan_done_reg <= scan_end;
            if (scan_end) begin
                scan_class_reg <= scan_class_next;
                scan_code_reg  <= key_decode(hit_idx);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .scan_done (scan_done_reg),
        .scan_class(scan_class_reg),
        .scan_code (scan_code_reg),
        .accept    (accept),
        .code      (accept_code)
    );

    // Entry register and last-key holding register, committed at the end of the accept cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code_reg <= '0;
            data_reg     <= '0;
        end else if (accept) begin
            key_code_reg <= accept_code;
            data_reg     <= {data_reg[11:0], accept_code};
        end
    end

    // The new key is visible on key_code/data in the same cycle as key_valid
    assign key_valid = accept;
    assign key_code  = accept ? accept_code : key_code_reg;
    assign data      = accept ? {data_reg[11:0], accept_code} : data_reg;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner: a per-scan reference model pushes
// expected accepts; a monitor pops and compares on every key_valid pulse.
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] data;

    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, column c held down

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit prev_valid = 1'b0;

    // Reference model state (per full scan)
    bit          m_held = 1'b0;
    int          m_run = 0;
    logic [3:0]  m_last = 4'h0;
    int          m_none = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_code = 4'h0;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    hex_keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_valid(key_valid),
        .key_code (key_code),
        .data     (data)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    function automatic void check(input string name, input logic [31:0] actual,
                                  input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endfunction

    // Model one full scan: a stable single key for 3 scans is accepted once,
    // then nothing more until 3 consecutive empty scans.
    function automatic void model_scan(input logic [15:0] p);
        int n;
        int idx;
        logic [3:0] k;
        n = $countones(p);
        idx = 0;
        for (int i = 0; i < 16; i++) if (p[i]) idx = i;
        if (!m_held) begin
            if (n == 1) begin
                k = keymap[idx];
                if (m_run > 0 && k == m_last) m_run++;
                else begin
                    m_run  = 1;
                    m_last = k;
                end
                if (m_run == 3) begin
                    m_data = {m_data[11:0], k};
                    m_code = k;
                    exp_q.push_back('{code: k, data: m_data});
                    m_held = 1'b1;
                    m_none = 0;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_none++;
                if (m_none == 3) m_held = 1'b0;
            end else begin
                m_none = 0;
            end
        end
    endfunction

    function automatic void model_reset();
        m_held = 1'b0;
        m_run  = 0;
        m_none = 0;
        m_data = 16'h0;
        m_code = 4'h0;
    endfunction

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (col !== target && n < 200);
        if (col !== target) begin
            checks++;
            errors++;
            $display("FAIL col_timeout actual=%b expected=%b", col, target);
        end
    endtask

    // Present pattern p for exactly one full scan, starting at the column-0 slot
    task automatic apply_scan(input logic [15:0] p);
        wait_col(4'b0111);
        wait_col(4'b1110);
        pressed = p;
        model_scan(p);
    endtask

    task automatic hold(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) apply_scan(p);
    endtask

    // Monitor: compare every pulse against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (key_valid) begin
                    exp_t e;
                    pulses++;
                    check("pulse_width", {31'd0, prev_valid}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse actual_code=%0h data=%0h expected=no pulse",
                                 key_code, data);
                    end else begin
                        e = exp_q.pop_front();
                        check("key_code", {28'd0, key_code}, {28'd0, e.code});
                        check("data", {16'd0, data}, {16'd0, e.data});
                    end
                end
                prev_valid = key_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        int p0;
        int r;
        int a;
        int b;
        logic [15:0] p;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_data", {16'd0, data}, 32'd0);
        reset = 1'b1;

        // Test 1: idle column rotation, 4 clocks per column
        for (int i = 1; i <= 32; i++) begin
            logic [3:0] one;
            @(negedge clk);
            one = 4'b0001;
            check("col_rotate", {28'd0, col}, {28'd0, ~(one << ((i >> 2) & 3))});
        end
        check("idle_data", {16'd0, data}, 32'd0);
        check("idle_pulses", pulses, 0);

        // Test 2: r1/c2 held 5 scans -> one accept of 6
        p0 = pulses;
        hold(16'h1 << 6, 5);
        hold(16'h0, 4);
        check("t2_pulses", pulses - p0, 1);
        check("t2_data", {16'd0, data}, 32'h0006);
        check("t2_code", {28'd0, key_code}, 32'h6);

        // Test 3: bouncing r0/c0 never accepted
        p0 = pulses;
        hold(16'h1, 2);
        hold(16'h0, 1);
        hold(16'h1, 2);
        hold(16'h0, 4);
        check("t3_pulses", pulses - p0, 0);
        check("t3_data", {16'd0, data}, 32'h0006);

        // Test 4: enter 1,2,3,A,5
        p0 = pulses;
        hold(16'h1 << 0, 4); hold(16'h0, 4);
        hold(16'h1 << 1, 4); hold(16'h0, 4);
        hold(16'h1 << 2, 4); hold(16'h0, 4);
        hold(16'h1 << 3, 4); hold(16'h0, 4);
        hold(16'h1 << 5, 4); hold(16'h0, 4);
        check("t4_pulses", pulses - p0, 5);
        check("t4_data", {16'd0, data}, 32'h23A5);

        // Test 5: two keys from idle, then roll-over while held
        p0 = pulses;
        hold((16'h1 << 0) | (16'h1 << 9), 4);
        hold(16'h0, 4);
        check("t5_multi_pulses", pulses - p0, 0);
        hold(16'h1 << 4, 4);
        hold((16'h1 << 4) | (16'h1 << 9), 3);
        hold(16'h1 << 9, 4);
        hold(16'h0, 4);
        check("t5_pulses", pulses - p0, 1);
        check("t5_data", {16'd0, data}, 32'h3A54);

        // Test 6: reset during the debounce of 9
        hold(16'h1 << 10, 2);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        pressed = 16'h0;
        #1;
        check("t6_col", {28'd0, col}, 32'hE);
        check("t6_valid", {31'd0, key_valid}, 32'd0);
        check("t6_code", {28'd0, key_code}, 32'd0);
        check("t6_data", {16'd0, data}, 32'd0);
        check("t6_pending", exp_q.size(), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        p0 = pulses;
        hold(16'h1 << 10, 2);
        check("t6_early_pulses", pulses - p0, 0);
        hold(16'h1 << 10, 1);
        hold(16'h0, 4);
        check("t6_pulses", pulses - p0, 1);
        check("t6_data9", {16'd0, data}, 32'h0009);

        // Randomised key activity against the reference model
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            a = int'($urandom_range(0, 15));
            if (r < 7) begin
                p = 16'h1 << a;
            end else if (r < 9) begin
                b = (a + int'($urandom_range(1, 15))) % 16;
                p = (16'h1 << a) | (16'h1 << b);
            end else begin
                p = 16'h0;
            end
            hold(p, int'($urandom_range(1, 5)));
            hold(16'h0, int'($urandom_range(0, 4)));
        end
        hold(16'h0, 4);
        check("rand_data", {16'd0, data}, {16'd0, m_data});
        check("rand_code", {28'd0, key_code}, {28'd0, m_code});
        check("missing_pulses", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
